alu_seq: RTL

Parametrised, sequential successor to the combinational ALU. It registers each operation, reports status flags, and computes multiply iteratively with a shift-add unit. Operands enter on a valid/ready handshake, and results leave on a second valid/ready handshake with a one-entry output register. The block sits between an operand source (sequencer or register file) and a result consumer that may apply backpressure.

---
 rtl/alu_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on both sides.
// Non-MUL opcodes complete in one cycle. MUL runs a WIDTH-step shift-add
// loop and then loads into the one-entry output register.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_inA,
  input  logic [WIDTH-1:0]     i_inB,
  input  logic [2:0]           i_s,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_ALU,
  output logic                 o_zero,
  output logic                 o_carry,
  output logic                 o_err
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [W2-1:0] SHL_LIM  = W2'(W2);
  localparam logic [W2-1:0] SHR_LIM  = W2'(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [W2-1:0]   acc_reg;
  logic [W2-1:0]   a_sh_reg;   // A shifted left by the current bit position
  logic [WIDTH-1:0] b_reg;     // remaining multiplier bits, LSB is current

  logic [W2-1:0]   a_ext;
  logic [W2-1:0]   b_ext;
  logic [W2-1:0]   sum;
  logic [W2-1:0]   diff;
  logic [W2-1:0]   acc_next;
  logic [W2-1:0]   op_result;
  logic            op_carry;
  logic            op_err;
  logic            accept;
  logic            transfer;
  logic            mul_done;

  assign a_ext = {{WIDTH{1'b0}}, i_inA};
  assign b_ext = {{WIDTH{1'b0}}, i_inB};
  assign sum   = a_ext + b_ext;
  assign diff  = a_ext - b_ext;

  // One shift-add step: add the shifted multiplicand when the current B bit is set.
  assign acc_next = acc_reg + (b_reg[0] ? a_sh_reg : '0);

  // New work is taken only when idle and the output slot is free or draining now.
  assign o_ready  = !i_rst && (state_reg == S_IDLE) && (!o_valid || i_ready);
  assign accept   = i_valid && o_ready;
  assign transfer = o_valid && i_ready;
  assign mul_done = (state_reg == S_MUL) && (count_reg == CNT_LAST);

  // Single-cycle opcode evaluation on the incoming operands.
  always_comb begin
    op_result = '0;
    op_carry  = 1'b0;
    op_err    = 1'b0;
    case (i_s)
      OP_MUL: op_result = '0;
      OP_ADD: begin
        op_result = sum;
        op_carry  = sum[WIDTH];
      end
      OP_SUB: begin
        op_result = diff;
        op_carry  = (i_inA < i_inB);
      end
      OP_SHL: op_result = (b_ext >= SHL_LIM) ? '0 : (a_ext << i_inB);
      OP_SHR: op_result = (b_ext >= SHR_LIM) ? '0 : (a_ext >> i_inB);
      OP_CMP: op_result = {{(W2-3){1'b0}}, (i_inA > i_inB), (i_inA == i_inB), (i_inA < i_inB)};
      default: begin
        op_result = '0;
        op_err    = 1'b1;
      end
    endcase
  end

  // Control FSM, multiply datapath and the output register in one process.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      acc_reg   <= '0;
      a_sh_reg  <= '0;
      b_reg     <= '0;
      o_valid   <= 1'b0;
      o_ALU     <= '0;
      o_zero    <= 1'b0;
      o_carry   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            if (i_s == OP_MUL) begin
              state_reg <= S_MUL;
              count_reg <= CNT_INIT;
              acc_reg   <= '0;
              a_sh_reg  <= a_ext;
              b_reg     <= i_inB;
              if (transfer) o_valid <= 1'b0;
            end else begin
              o_ALU   <= op_result;
              o_zero  <= (op_result == '0);
              o_carry <= op_carry;
              o_err   <= op_err;
              o_valid <= 1'b1;
            end
          end else if (transfer) begin
            o_valid <= 1'b0;
          end
        end
        S_MUL: begin
          acc_reg   <= acc_next;
          a_sh_reg  <= a_sh_reg << 1;
          b_reg     <= b_reg >> 1;
          count_reg <= count_reg - CNT_LAST;
          if (mul_done) begin
            // The output slot was emptied when this MUL was accepted.
            state_reg <= S_IDLE;
            o_ALU     <= acc_next;
            o_zero    <= (acc_next == '0);
            o_carry   <= 1'b0;
            o_err     <= 1'b0;
            o_valid   <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
